sync_detector: RTL and testbench

Front-end sync stage for the capture path. Samples the raw active-low sync input into a shift register and emits a clean, registered one-cycle `hsync` pulse; that pulse drives the asynchronous `rst` of the per-line pixel counter downstream. The block also:
- detects long low runs as `vsync`;
- measures the line period;
- counts lines;
- runs a lock state machine that tells later stages when line timing is stable.

---
 rtl/sync_detector.sv | 175 +++++++++++++++++
 tb/tb_sync_detector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_detector.sv
// Front-end sync stage: qualifies hsync/vsync from the raw active-low sync input,
// measures the line period, counts lines and tracks line-timing lock.
module sync_detector #(
    parameter int HS_LEN     = 8,
    parameter int VSYNC_LEN  = 64,
    parameter int PWIDTH     = 12,
    parameter int LWIDTH     = 10,
    parameter int TOL        = 2,
    parameter int LOCK_LINES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_in,
    output logic              hsync,
    output logic              vsync,
    output logic              locked,
    output logic [PWIDTH-1:0] line_period,
    output logic [LWIDTH-1:0] line_count,
    output logic [1:0]        lock_state
);

    localparam int RUN_W   = $clog2(VSYNC_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_LINES + 1);

    localparam logic [PWIDTH-1:0]  PERIOD_MAX = {PWIDTH{1'b1}};
    localparam logic [PWIDTH-1:0]  PERIOD_PRE = PERIOD_MAX - 1'b1;
    localparam logic [PWIDTH-1:0]  TOL_P      = PWIDTH'(TOL);
    localparam logic [LWIDTH-1:0]  COUNT_MAX  = {LWIDTH{1'b1}};
    localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(VSYNC_LEN);
    localparam logic [RUN_W-1:0]   RUN_PRE    = RUN_W'(VSYNC_LEN - 1);
    localparam logic [MATCH_W-1:0] LOCK_M     = MATCH_W'(LOCK_LINES);

    // Encoding is visible on lock_state for observation.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } lock_state_t;

    logic [HS_LEN:0]      shreg;
    logic [RUN_W-1:0]     low_run;
    logic [PWIDTH-1:0]    period_cnt;
    logic [PWIDTH-1:0]    period_diff;
    logic [MATCH_W-1:0]   match_cnt;
    logic [MATCH_W-1:0]   match_cnt_next;
    lock_state_t          state;
    lock_state_t          next_state;
    logic                 hs_det;
    logic                 vs_det;
    logic                 timeout;
    logic                 period_match;

    // One high sample followed by exactly HS_LEN lows; longer runs cannot re-trigger
    // because the oldest bit stays low until a high sample re-arms detection.
    assign hs_det = shreg[HS_LEN] && (shreg[HS_LEN-1:0] == '0);

    // low_run counts the sampled stream, so vsync lands VSYNC_LEN edges after the first low.
    assign vs_det = !shreg[0] && (low_run == RUN_PRE);

    // Fires on the edge where period_cnt would reach its saturation value.
    assign timeout = !hs_det && (period_cnt >= PERIOD_PRE);

    assign period_diff  = (period_cnt >= line_period) ? (period_cnt - line_period)
                                                      : (line_period - period_cnt);
    assign period_match = (period_diff <= TOL_P);

    assign lock_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '1;
            low_run <= '0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
        end else begin
            shreg <= {shreg[HS_LEN-1:0], sync_in};
            if (shreg[0]) begin
                low_run <= '0;
            end else if (low_run != RUN_MAX) begin
                low_run <= low_run + 1'b1;
            end
            hsync <= hs_det;
            vsync <= vs_det;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt  <= '0;
            line_period <= '0;
            line_count  <= '0;
        end else begin
            if (hs_det) begin
                period_cnt  <= {{(PWIDTH-1){1'b0}}, 1'b1};
                line_period <= period_cnt;
            end else if (period_cnt != PERIOD_MAX) begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (hs_det) begin
                if (line_count != COUNT_MAX) begin
                    line_count <= line_count + 1'b1;
                end
            end else if (vs_det) begin
                line_count <= '0;
            end
        end
    end

    always_comb begin
        next_state     = state;
        match_cnt_next = match_cnt;
        case (state)
            SEARCH: begin
                match_cnt_next = '0;
                if (hs_det) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (hs_det) begin
                    next_state     = TRACK;
                    match_cnt_next = '0;
                end else if (timeout) begin
                    next_state     = SEARCH;
                    match_cnt_next = '0;
                end
            end
            TRACK: begin
                if (hs_det) begin
                    if (period_match) begin
                        match_cnt_next = match_cnt + 1'b1;
                        if (match_cnt_next == LOCK_M) begin
                            next_state = LOCKED;
                        end
                    end else begin
                        match_cnt_next = '0;
                    end
                end else if (timeout) begin
                    next_state     = SEARCH;
                    match_cnt_next = '0;
                end
            end
            LOCKED: begin
                if (hs_det) begin
                    if (!period_match) begin
                        next_state     = TRACK;
                        match_cnt_next = '0;
                    end
                end else if (timeout) begin
                    next_state     = SEARCH;
                    match_cnt_next = '0;
                end
            end
            default: begin
                next_state     = SEARCH;
                match_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            match_cnt <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= next_state;
            match_cnt <= match_cnt_next;
            locked    <= (next_state == LOCKED);
        end
    end

endmodule

// File: tb/tb_sync_detector.sv
// Testbench for sync_detector: directed line tables, hand-written corner sequences
// and randomized sync traffic against a sample-history reference model.
module tb_sync_detector;

    localparam int HS_LEN     = 8;
    localparam int VSYNC_LEN  = 64;
    localparam int PWIDTH     = 8;
    localparam int LWIDTH     = 4;
    localparam int TOL        = 2;
    localparam int LOCK_LINES = 4;
    localparam int PMAX       = (1 << PWIDTH) - 1;
    localparam int LMAX       = (1 << LWIDTH) - 1;
    localparam int SEARCH_CODE = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync_in = 1'b1;
    logic              hsync;
    logic              vsync;
    logic              locked;
    logic [PWIDTH-1:0] line_period;
    logic [LWIDTH-1:0] line_count;
    logic [1:0]        lock_state;

    sync_detector #(
        .HS_LEN     (HS_LEN),
        .VSYNC_LEN  (VSYNC_LEN),
        .PWIDTH     (PWIDTH),
        .LWIDTH     (LWIDTH),
        .TOL        (TOL),
        .LOCK_LINES (LOCK_LINES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_in     (sync_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .locked      (locked),
        .line_period (line_period),
        .line_count  (line_count),
        .lock_state  (lock_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_hs;
    int n_vs;

    typedef struct {
        int len;
        int exp_locked;
        int exp_period;
        int exp_count;
    } line_vec_t;

    line_vec_t lines [14];

    // Reference model: zero-run length of the sample history, cycles since the last
    // hsync, and a streak of matching periods since the last restart.
    int m_zrun, m_elapsed, m_since, m_streak, m_period, m_count;
    bit m_hs, m_vs, m_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_zrun = 0; m_elapsed = 0; m_since = 0; m_streak = 0;
        m_period = 0; m_count = 0;
        m_hs = 1'b0; m_vs = 1'b0; m_locked = 1'b0;
    endtask

    task automatic model_edge(input logic v);
        int gap;
        int dev;
        m_hs = (m_zrun == HS_LEN);
        m_vs = (m_zrun == VSYNC_LEN);
        if (m_hs) begin
            gap = m_elapsed;
            if (m_since >= 2) begin
                dev = (gap > m_period) ? gap - m_period : m_period - gap;
                if (dev <= TOL) m_streak++;
                else m_streak = 0;
            end else begin
                m_streak = 0;
            end
            if (m_since < 2) m_since++;
            m_period  = gap;
            m_elapsed = 1;
            if (m_count < LMAX) m_count++;
        end else begin
            if (m_elapsed < PMAX) m_elapsed++;
            if (m_elapsed == PMAX) begin
                m_since  = 0;
                m_streak = 0;
            end
        end
        if (m_vs) m_count = 0;
        m_locked = (m_since >= 2) && (m_streak >= LOCK_LINES);
        m_zrun = v ? 0 : m_zrun + 1;
    endtask

    task automatic step(input logic v);
        sync_in = v;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(v);
        @(negedge clk);
        if (hsync === 1'b1) n_hs++;
        if (vsync === 1'b1) n_vs++;
        check("model_hsync", hsync, m_hs);
        check("model_vsync", vsync, m_vs);
        check("model_locked", locked, m_locked);
        check("model_line_period", line_period, m_period);
        check("model_line_count", line_count, m_count);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sync_in = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_line(input int len, input int exp_lk, input int exp_per, input int exp_cnt);
        for (int i = 0; i < len; i++) begin
            step(i < HS_LEN ? 1'b0 : 1'b1);
            if (i == HS_LEN) begin
                check("line_hsync", hsync, 1);
                check("line_locked", locked, exp_lk);
                if (exp_per >= 0) check("line_period", line_period, exp_per);
                check("line_count", line_count, exp_cnt);
            end
        end
    endtask

    initial begin
        lines[0]  = '{200, 0,  -1,  1};
        lines[1]  = '{200, 0, 200,  2};
        lines[2]  = '{200, 0, 200,  3};
        lines[3]  = '{200, 0, 200,  4};
        lines[4]  = '{200, 0, 200,  5};
        lines[5]  = '{202, 1, 200,  6};
        lines[6]  = '{200, 1, 202,  7};
        lines[7]  = '{203, 1, 200,  8};
        lines[8]  = '{203, 0, 203,  9};
        lines[9]  = '{203, 0, 203, 10};
        lines[10] = '{203, 0, 203, 11};
        lines[11] = '{203, 0, 203, 12};
        lines[12] = '{203, 1, 203, 13};
        lines[13] = '{9,   1, 203, 14};

        // Reset values and idle line
        apply_reset();
        check("reset_hsync", hsync, 0);
        check("reset_vsync", vsync, 0);
        check("reset_locked", locked, 0);
        check("reset_line_period", line_period, 0);
        check("reset_line_count", line_count, 0);
        n_hs = 0; n_vs = 0;
        repeat (100) step(1'b1);
        check("idle_hsync_pulses", n_hs, 0);
        check("idle_vsync_pulses", n_vs, 0);
        check("idle_locked", locked, 0);
        check("idle_line_count", line_count, 0);

        // Single hsync: lows on edges 10..17, pulse only on edge 18
        apply_reset();
        n_hs = 0;
        for (int e = 0; e < 40; e++) begin
            step((e >= 10 && e < 18) ? 1'b0 : 1'b1);
            check("single_hsync_edge", hsync, (e == 18) ? 1 : 0);
        end
        check("single_hsync_pulses", n_hs, 1);

        // A 20-sample low run yields exactly one hsync
        n_hs = 0;
        for (int i = 0; i < 30; i++) begin
            step(i < 20 ? 1'b0 : 1'b1);
            if (i == HS_LEN) check("long_run_hsync_pos", hsync, 1);
        end
        check("long_run_hsync_pulses", n_hs, 1);

        // Periodic lines, tolerance, drop and re-lock
        apply_reset();
        repeat (5) step(1'b1);
        for (int k = 0; k < 14; k++) begin
            run_line(lines[k].len, lines[k].exp_locked, lines[k].exp_period, lines[k].exp_count);
        end

        // Timeout: locked holds until period_cnt reaches its maximum
        repeat (PMAX - 2) step(1'b1);
        check("pre_timeout_locked", locked, 1);
        step(1'b1);
        check("timeout_locked", locked, 0);
        check("timeout_state_search", lock_state, SEARCH_CODE);
        run_line(20, 0, PMAX, 15);

        // vsync run: hsync at +8 with saturated count, vsync at +64 clears the count
        n_vs = 0;
        for (int i = 0; i < 80; i++) begin
            step(i < 70 ? 1'b0 : 1'b1);
            if (i == HS_LEN) begin
                check("vs_run_hsync", hsync, 1);
                check("vs_run_count_sat", line_count, LMAX);
            end
            if (i == VSYNC_LEN) begin
                check("vs_run_vsync", vsync, 1);
                check("vs_run_count_clear", line_count, 0);
            end
        end
        check("vs_run_vsync_pulses", n_vs, 1);

        // Re-lock on 50-cycle lines, then reset while hsync is high
        run_line(50, 0, 80, 1);
        run_line(50, 0, 50, 2);
        run_line(50, 0, 50, 3);
        run_line(50, 0, 50, 4);
        run_line(50, 0, 50, 5);
        run_line(50, 1, 50, 6);
        for (int i = 0; i <= HS_LEN; i++) step(i < HS_LEN ? 1'b0 : 1'b1);
        check("pre_reset_hsync", hsync, 1);
        check("pre_reset_locked", locked, 1);
        check("pre_reset_line_period", line_period, 50);
        check("pre_reset_line_count", line_count, 7);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_reset_hsync", hsync, 0);
        check("async_reset_vsync", vsync, 0);
        check("async_reset_locked", locked, 0);
        check("async_reset_line_period", line_period, 0);
        check("async_reset_line_count", line_count, 0);
        @(negedge clk);
        repeat (5) step(1'b0);
        rst = 1'b0;
        n_hs = 0; n_vs = 0;
        repeat (30) step(1'b1);
        check("release_hsync_pulses", n_hs, 0);
        check("release_vsync_pulses", n_vs, 0);

        // Randomized traffic: jittered lines, short glitches, vsync runs and timeouts
        apply_reset();
        for (int s = 0; s < 160; s++) begin
            int r;
            int low;
            int high;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                low  = $urandom_range(60, 72);
                high = $urandom_range(1, 20);
            end else if (r == 1) begin
                low  = $urandom_range(1, 12);
                high = $urandom_range(250, 300);
            end else begin
                low  = $urandom_range(1, 12);
                high = 60 + $urandom_range(0, 4) - low;
            end
            repeat (low) step(1'b0);
            repeat (high) step(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
